wr_burst_fram_buf: RTL and testbench



---
 rtl/wr_burst_fram_buf_pkg.sv | 16 +
 rtl/wr_burst_fram_buf_if.sv | 33 +++
 rtl/wr_burst_fram_buf_bank_ram.sv | 24 ++
 rtl/wr_burst_fram_buf.sv | 206 ++++++++++++++++++++
 tb/tb_wr_burst_fram_buf.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wr_burst_fram_buf_pkg.sv
// Shared definitions for the write-side frame buffer.
//   rd_state_t : reader FSM states (idle, burst request, streaming).
//   idx_w()    : index width for a count of n items, never below 1 bit.
package wr_burst_fram_buf_pkg;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_REQ    = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wr_burst_fram_buf_if.sv
// Bus bundle for the write-side frame buffer.
//   Capture side : frame_start, in_valid, in_data, in_last, overflow.
//   Burst side   : out_req, out_len, out_ack (burst handshake) and
//                  out_valid, out_data, out_last, out_ready (beat stream).
//   master : the buffer itself; slave : the surrounding capture/memory side.
interface wr_burst_fram_buf_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 128,
  parameter int LEN_W = 7
);
  logic             frame_start;
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_last;
  logic             out_req;
  logic [LEN_W-1:0] out_len;
  logic             out_ack;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             overflow;

  modport master (
    input  frame_start, in_valid, in_data, in_last, out_ack, out_ready,
    output out_req, out_len, out_valid, out_data, out_last, overflow
  );

  modport slave (
    output frame_start, in_valid, in_data, in_last, out_ack, out_ready,
    input  out_req, out_len, out_valid, out_data, out_last, overflow
  );
endinterface

// File: rtl/wr_burst_fram_buf_bank_ram.sv
// Simple dual-port beat store holding both ping-pong banks.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid one cycle after re
// Address is {bank, beat}. No read/write ordering guarantee on collision.
module wr_burst_fram_buf_bank_ram #(
  parameter int W  = 128,
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/wr_burst_fram_buf.sv
// Write-side frame buffer: packs IN_W pixel words LSB-first into OUT_W beats,
// fills two ping-pong banks of BURST_LEN beats, and for each closed bank
// offers a burst (out_req/out_len/out_ack) then streams it (valid/ready).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : master side of wr_burst_fram_buf_if (see interface header)
module wr_burst_fram_buf
  import wr_burst_fram_buf_pkg::*;
#(
  parameter int IN_W      = 32,
  parameter int OUT_W     = 128,
  parameter int BURST_LEN = 64,
  parameter int LEN_W     = $clog2(BURST_LEN + 1)
) (
  input logic clk,
  input logic rst_n,
  wr_burst_fram_buf_if.master bus
);
  localparam int RATIO = OUT_W / IN_W;
  localparam int SW    = idx_w(RATIO);
  localparam int BAW   = idx_w(BURST_LEN);
  localparam int RAW   = BAW + 1;

  // Writer state
  logic [SW-1:0]    scnt_reg;
  logic [BAW-1:0]   wcnt_reg;
  logic             wb_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [1:0]       full_reg;
  logic [LEN_W-1:0] len_reg [2];
  logic             ovf_reg;

  // Reader state
  rd_state_t        state_reg;
  logic             rb_reg;
  logic [LEN_W-1:0] icnt_reg;
  logic             pend_reg, pend_last_reg;
  logic             v0_reg, v1_reg, l0_reg, l1_reg;
  logic [OUT_W-1:0] d0_reg, d1_reg;
  logic             out_req_reg;
  logic [LEN_W-1:0] out_len_reg;

  // frame_start makes this cycle's word behave as if state were already clear.
  logic [SW-1:0]    scnt_cur;
  logic [BAW-1:0]   wcnt_cur;
  logic             wb_cur;
  logic [OUT_W-1:0] acc_cur;
  logic [1:0]       full_cur, full_next;
  logic [OUT_W-1:0] wr_data, ram_rdata;
  logic             rd_free, bank_busy, accept, beat_done, bank_done;
  logic             pop, room, rd_issue, issue_last;
  logic [1:0]       occ_after;
  logic [RAW-1:0]   rd_addr;

  assign scnt_cur = bus.frame_start ? '0 : scnt_reg;
  assign wcnt_cur = bus.frame_start ? '0 : wcnt_reg;
  assign wb_cur   = bus.frame_start ? 1'b0 : wb_reg;
  assign acc_cur  = bus.frame_start ? '0 : acc_reg;
  assign full_cur = bus.frame_start ? 2'b00 : full_reg;

  // Final beat accepted this cycle: its bank is usable by this cycle's word.
  assign pop       = v0_reg && bus.out_ready;
  assign rd_free   = !bus.frame_start && pop && l0_reg;
  assign bank_busy = full_cur[wb_cur] && !(rd_free && (rb_reg == wb_cur));
  assign accept    = bus.in_valid && !bank_busy;
  assign beat_done = accept && (bus.in_last || scnt_cur == SW'(RATIO - 1));
  assign bank_done = beat_done && (bus.in_last || wcnt_cur == BAW'(BURST_LEN - 1));

  // Lanes above the current word are always zero in the accumulator, which
  // provides the zero padding for a partial beat closed by in_last.
  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign wr_data[gi*IN_W +: IN_W] = (scnt_cur == SW'(gi)) ? bus.in_data
                                                              : acc_cur[gi*IN_W +: IN_W];
    end
  endgenerate

  // Close wins over free so a one-word bank closed on its bypass cycle stays full.
  always_comb begin
    full_next = full_cur;
    if (rd_free) full_next[rb_reg] = 1'b0;
    if (bank_done) full_next[wb_cur] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt_reg <= '0;
      wcnt_reg <= '0;
      wb_reg   <= 1'b0;
      acc_reg  <= '0;
      full_reg <= 2'b00;
      ovf_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) len_reg[i] <= '0;
    end else begin
      scnt_reg <= scnt_cur;
      wcnt_reg <= wcnt_cur;
      wb_reg   <= wb_cur;
      acc_reg  <= acc_cur;
      full_reg <= full_next;
      if (bus.frame_start) ovf_reg <= 1'b0;
      if (bus.in_valid && bank_busy) ovf_reg <= 1'b1;
      if (accept) begin
        if (beat_done) begin
          acc_reg  <= '0;
          scnt_reg <= '0;
          if (bank_done) begin
            len_reg[wb_cur] <= LEN_W'(wcnt_cur) + LEN_W'(1);
            wb_reg          <= ~wb_cur;
            wcnt_reg        <= '0;
          end else begin
            wcnt_reg <= wcnt_cur + BAW'(1);
          end
        end else begin
          acc_reg  <= wr_data;
          scnt_reg <= scnt_cur + SW'(1);
        end
      end
    end
  end

  // Reads are issued only while the skid buffer can absorb the returning beat;
  // the first read goes out on the ack cycle to keep first-beat latency at 2.
  assign occ_after  = {1'b0, v0_reg} + {1'b0, v1_reg} + {1'b0, pend_reg} - {1'b0, pop};
  assign room       = occ_after < 2'd2;
  assign rd_issue   = !bus.frame_start &&
                      (((state_reg == RD_REQ) && bus.out_ack) ||
                       ((state_reg == RD_STREAM) && (icnt_reg < out_len_reg) && room));
  assign issue_last = (icnt_reg == out_len_reg - LEN_W'(1));
  assign rd_addr    = {rb_reg, icnt_reg[BAW-1:0]};

  wr_burst_fram_buf_bank_ram #(.W(OUT_W), .AW(RAW)) u_ram (
    .clk   (clk),
    .we    (beat_done),
    .waddr ({wb_cur, wcnt_cur}),
    .wdata (wr_data),
    .re    (rd_issue),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RD_IDLE;  rb_reg <= 1'b0;  icnt_reg <= '0;
      pend_reg <= 1'b0;  pend_last_reg <= 1'b0;
      v0_reg <= 1'b0;  v1_reg <= 1'b0;  l0_reg <= 1'b0;  l1_reg <= 1'b0;
      d0_reg <= '0;  d1_reg <= '0;  out_req_reg <= 1'b0;  out_len_reg <= '0;
    end else if (bus.frame_start) begin
      state_reg <= RD_IDLE;  rb_reg <= 1'b0;  icnt_reg <= '0;
      pend_reg <= 1'b0;  pend_last_reg <= 1'b0;
      v0_reg <= 1'b0;  v1_reg <= 1'b0;  l0_reg <= 1'b0;  l1_reg <= 1'b0;
      d0_reg <= '0;  d1_reg <= '0;  out_req_reg <= 1'b0;  out_len_reg <= '0;
    end else begin
      pend_reg      <= rd_issue;
      pend_last_reg <= issue_last;
      if (rd_issue) icnt_reg <= icnt_reg + LEN_W'(1);

      // Two-entry skid: entry 0 drives the outputs, entry 1 catches the
      // in-flight read when the head stalls.
      if (pop && pend_reg) begin
        if (v1_reg) begin
          d0_reg <= d1_reg;     l0_reg <= l1_reg;
          d1_reg <= ram_rdata;  l1_reg <= pend_last_reg;
        end else begin
          d0_reg <= ram_rdata;  l0_reg <= pend_last_reg;
        end
      end else if (pop) begin
        d0_reg <= d1_reg;
        l0_reg <= v1_reg && l1_reg;
        v0_reg <= v1_reg;
        v1_reg <= 1'b0;
      end else if (pend_reg) begin
        if (!v0_reg) begin
          d0_reg <= ram_rdata;  l0_reg <= pend_last_reg;  v0_reg <= 1'b1;
        end else begin
          d1_reg <= ram_rdata;  l1_reg <= pend_last_reg;  v1_reg <= 1'b1;
        end
      end

      case (state_reg)
        RD_IDLE: if (full_reg[rb_reg]) begin
          state_reg   <= RD_REQ;
          out_req_reg <= 1'b1;
          out_len_reg <= len_reg[rb_reg];
          icnt_reg    <= '0;
        end
        RD_REQ: if (bus.out_ack) begin
          state_reg   <= RD_STREAM;
          out_req_reg <= 1'b0;
        end
        RD_STREAM: if (rd_free) begin
          state_reg <= RD_IDLE;
          rb_reg    <= ~rb_reg;
          icnt_reg  <= '0;
        end
        default: state_reg <= RD_IDLE;
      endcase
    end
  end

  assign bus.out_req   = out_req_reg;
  assign bus.out_len   = out_len_reg;
  assign bus.out_valid = v0_reg;
  assign bus.out_data  = d0_reg;
  assign bus.out_last  = l0_reg;
  assign bus.overflow  = ovf_reg;
endmodule

// File: tb/tb_wr_burst_fram_buf.sv
module tb_wr_burst_fram_buf;
  localparam int IN_W = 32, OUT_W = 128, BURST_LEN = 64, LEN_W = 7;
  localparam int RATIO = OUT_W / IN_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wr_burst_fram_buf_if #(.IN_W(IN_W), .OUT_W(OUT_W), .LEN_W(LEN_W)) bus ();

  wr_burst_fram_buf #(.IN_W(IN_W), .OUT_W(OUT_W), .BURST_LEN(BURST_LEN), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: words of the open bank, then the expected beat stream of
  // closed bursts, their lengths, and how many closed bursts are not yet drained.
  logic [31:0]  cur_words [$];
  logic [127:0] exp_beats [$];
  logic         exp_lastq [$];
  int           exp_len [$];
  int           outstanding;
  logic         exp_ovf;

  int           beat_cnt, phase_beats;
  logic [127:0] beat_log [BURST_LEN];
  int           ready_mode, ack_mode;
  logic         rdy_tog;
  logic         prev_stall, prev_last, lat_wait, prev_ack_hs, fs_check, fs_armed, fs_fired;
  logic [127:0] prev_data;
  int           lat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    cur_words.delete();
    exp_beats.delete();
    exp_lastq.delete();
    exp_len.delete();
    outstanding = 0;
    exp_ovf = 1'b0;
    beat_cnt = 0;
    prev_stall = 1'b0;
    lat_wait = 1'b0;
    lat = 0;
    prev_ack_hs = 1'b0;
  endtask

  task automatic close_bank();
    int n, nb, idx;
    logic [127:0] beat;
    n  = cur_words.size();
    nb = (n + RATIO - 1) / RATIO;
    for (int b = 0; b < nb; b++) begin
      beat = '0;
      for (int k = 0; k < RATIO; k++) begin
        idx = b * RATIO + k;
        if (idx < n) beat = beat | ({96'b0, cur_words[idx]} << (k * IN_W));
      end
      exp_beats.push_back(beat);
      exp_lastq.push_back(b == nb - 1);
    end
    exp_len.push_back(nb);
    outstanding++;
    cur_words.delete();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_req"},   128'(bus.out_req),   128'(0));
    chk({tag, "_out_len"},   128'(bus.out_len),   128'(0));
    chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
    chk({tag, "_out_data"},  bus.out_data,        128'(0));
    chk({tag, "_out_last"},  128'(bus.out_last),  128'(0));
    chk({tag, "_overflow"},  128'(bus.overflow),  128'(0));
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic tick(input logic v, input logic [31:0] d, input logic l, input logic fs_in);
    logic fs;
    logic [127:0] eb;
    logic el;
    int   ln;
    fs = fs_in;
    if (fs_armed && beat_cnt == 10 && bus.out_valid) begin
      fs = 1'b1;
      fs_armed = 1'b0;
      fs_fired = 1'b1;
    end
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = rdy_tog; rdy_tog = ~rdy_tog; end
      default: bus.out_ready = ($urandom_range(0, 3) != 0);
    endcase
    case (ack_mode)
      0: bus.out_ack = 1'b1;
      1: bus.out_ack = 1'b0;
      default: bus.out_ack = ($urandom_range(0, 1) != 0);
    endcase
    bus.in_valid = v;
    bus.in_data = d;
    bus.in_last = l;
    bus.frame_start = fs;

    chk("overflow", 128'(bus.overflow), 128'(exp_ovf));
    if (fs_check) begin
      chk("fs_out_valid", 128'(bus.out_valid), 128'(0));
      chk("fs_out_req", 128'(bus.out_req), 128'(0));
      fs_check = 1'b0;
    end
    if (prev_ack_hs) begin
      chk("req_drop", 128'(bus.out_req), 128'(0));
      prev_ack_hs = 1'b0;
    end
    if (prev_stall) begin
      chk("stall_valid", 128'(bus.out_valid), 128'(1));
      chk("stall_data", bus.out_data, prev_data);
      chk("stall_last", 128'(bus.out_last), 128'(prev_last));
    end
    if (lat_wait) begin
      lat++;
      if (bus.out_valid || lat > 2) begin
        chk("ack_to_valid", 128'(lat <= 2), 128'(1));
        lat_wait = 1'b0;
      end
    end

    if (fs) begin
      model_clear();
      fs_check = 1'b1;
    end else begin
      if (bus.out_req && bus.out_ack) begin
        chk("burst_queued", 128'(exp_len.size() != 0), 128'(1));
        if (exp_len.size() != 0) begin
          ln = exp_len.pop_front();
          chk("out_len", 128'(bus.out_len), 128'(ln));
        end
        prev_ack_hs = 1'b1;
        lat = 0;
        lat_wait = 1'b1;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        chk("beat_queued", 128'(exp_beats.size() != 0), 128'(1));
        if (exp_beats.size() != 0) begin
          eb = exp_beats.pop_front();
          el = exp_lastq.pop_front();
          chk("out_data", bus.out_data, eb);
          chk("out_last", 128'(bus.out_last), 128'(el));
          if (beat_cnt < BURST_LEN) beat_log[beat_cnt] = bus.out_data;
          beat_cnt++;
          phase_beats++;
          if (el) begin
            outstanding--;
            beat_cnt = 0;
          end
        end
      end
    end

    if (v) begin
      if (outstanding >= 2) exp_ovf = 1'b1;
      else begin
        cur_words.push_back(d);
        if (l || cur_words.size() == RATIO * BURST_LEN) close_bank();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(outstanding == 0 && exp_beats.size() == 0 && exp_len.size() == 0) && n < 3000) begin
      tick(1'b0, 32'd0, 1'b0, 1'b0);
      n++;
    end
    chk({tag, "_drained"}, 128'(n < 3000), 128'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.frame_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.out_ack = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    ready_mode = 0;
    ack_mode = 0;
    rdy_tog = 1'b1;
    fs_armed = 1'b0;
    fs_fired = 1'b0;
    fs_check = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Full bank, ack held, ready held.
    phase_beats = 0;
    for (int i = 0; i < 256; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
    drain("full_bank");
    chk("full_bank_beats", 128'(phase_beats), 128'(64));
    chk("full_bank_beat0", beat_log[0], 128'h00000003_00000002_00000001_00000000);

    // Partial line flush.
    phase_beats = 0;
    for (int i = 0; i < 6; i++) tick(1'b1, 32'(i), i == 5, 1'b0);
    drain("partial");
    chk("partial_beats", 128'(phase_beats), 128'(2));
    chk("partial_beat1", beat_log[1], 128'h00000000_00000000_00000005_00000004);

    // Overflow: no ack, 513 words, then drain one bank and write again.
    ack_mode = 1;
    for (int i = 0; i <= 512; i++) tick(1'b1, 32'(i), 1'b0, 1'b0);
    tick(1'b0, 32'd0, 1'b0, 1'b0);
    chk("ovf_sticky", 128'(bus.overflow), 128'(1));
    chk("ovf_req_waiting", 128'(bus.out_req), 128'(1));
    ack_mode = 0;
    begin
      int n = 0;
      while (outstanding != 1 && n < 2000) begin
        tick(1'b0, 32'd0, 1'b0, 1'b0);
        n++;
      end
      chk("ovf_first_drain", 128'(outstanding == 1), 128'(1));
    end
    tick(1'b1, 32'd514, 1'b1, 1'b0);
    drain("ovf");
    chk("ovf_reuse_lane0", beat_log[0], 128'd514);
    tick(1'b0, 32'd0, 1'b0, 1'b1);

    // Alternating ready.
    ready_mode = 1;
    phase_beats = 0;
    for (int i = 0; i < 256; i++) tick(1'b1, 32'(i + 3000), 1'b0, 1'b0);
    drain("alt_ready");
    chk("alt_ready_beats", 128'(phase_beats), 128'(64));

    // frame_start during beat 10, then a clean frame.
    ready_mode = 0;
    fs_armed = 1'b1;
    fs_fired = 1'b0;
    for (int i = 0; i < 256; i++) tick(1'b1, 32'(i + 5000), 1'b0, 1'b0);
    drain("fs_abort");
    chk("fs_fired", 128'(fs_fired), 128'(1));
    tick(1'b0, 32'd0, 1'b0, 1'b1);
    phase_beats = 0;
    for (int i = 0; i < 256; i++) tick(1'b1, 32'(i + 1000), 1'b0, 1'b0);
    drain("fs_clean");
    chk("fs_clean_beats", 128'(phase_beats), 128'(64));
    chk("fs_clean_beat0", beat_log[0], 128'h000003eb_000003ea_000003e9_000003e8);

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 400; i++) begin
      if (beat_cnt >= 5) break;
      tick(1'b1, 32'(i), 1'b0, 1'b0);
    end
    chk("mid_stream_reached", 128'(beat_cnt >= 5), 128'(1));
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomised traffic with a stretch of withheld ack to force drops.
    ready_mode = 2;
    ack_mode = 2;
    for (int c = 0; c < 1800; c++) begin
      logic v, l;
      if (c == 600) ack_mode = 1;
      if (c == 1100) ack_mode = 2;
      v = ($urandom_range(0, 9) < 7);
      l = v && ($urandom_range(0, 49) == 0);
      tick(v, $urandom, l, 1'b0);
    end
    drain("random");
    tick(1'b1, $urandom, 1'b1, 1'b0);
    drain("random_tail");
    chk("random_ovf_seen", 128'(exp_ovf), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
